// File: rtl/midi_pkg.sv
// Shared MIDI constants, serializer state type and the status-to-length helper.
package midi_pkg;

    localparam int DEFAULT_BAUD = 31250;

    localparam logic [7:0] ST_NOTE_OFF   = 8'h80;
    localparam logic [7:0] ST_NOTE_ON    = 8'h90;
    localparam logic [7:0] ST_PROG_CHG   = 8'hC0;
    localparam logic [7:0] ST_CHAN_PRES  = 8'hD0;
    localparam logic [7:0] ST_PITCH_BEND = 8'hE0;
    localparam logic [7:0] ST_SYSTEM     = 8'hF0;
    localparam logic [7:0] ST_REALTIME   = 8'hF8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Bytes on the wire for a full message; 0 means "not a status byte".
    function automatic logic [1:0] msg_byte_count(input logic [7:0] status);
        if (status < ST_NOTE_OFF)
            return 2'd0;
        else if (status < ST_PROG_CHG)
            return 2'd3;
        else if (status < ST_PITCH_BEND)
            return 2'd2;
        else if (status < ST_SYSTEM)
            return 2'd3;
        else
            return 2'd1;
    endfunction

    function automatic logic is_channel(input logic [7:0] status);
        return (status >= ST_NOTE_OFF) && (status < ST_SYSTEM);
    endfunction

endpackage

// File: rtl/midi_tx_uart_tx_byte.sv
// 8N1 byte serializer; accepts a new byte while idle or on the last stop-bit cycle
// so consecutive bytes go out with no idle gap.
module uart_tx_byte
    import midi_pkg::*;
#(
    parameter int DIV = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    tx_state_t      state, state_n;
    logic [CW-1:0]  baud, baud_n;
    logic [2:0]     bit_idx, bit_n;
    logic [7:0]     sh, sh_n;
    logic           tx_q, tx_n;
    logic           wrap;

    assign wrap = (baud == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= TX_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            sh      <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            sh      <= sh_n;
            tx_q    <= tx_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = wrap ? '0 : baud + 1'b1;
        bit_n   = bit_idx;
        sh_n    = sh;
        done    = 1'b0;
        case (state)
            TX_IDLE: begin
                baud_n = '0;
                if (start) begin
                    state_n = TX_START;
                    sh_n    = data;
                end
            end
            TX_START: begin
                if (wrap) begin
                    state_n = TX_DATA;
                    bit_n   = '0;
                end
            end
            TX_DATA: begin
                if (wrap) begin
                    bit_n = bit_idx + 3'd1;
                    sh_n  = sh >> 1;
                    if (bit_idx == 3'd7)
                        state_n = TX_STOP;
                end
            end
            TX_STOP: begin
                if (wrap) begin
                    done = 1'b1;
                    if (start) begin
                        state_n = TX_START;
                        sh_n    = data;
                    end else begin
                        state_n = TX_IDLE;
                    end
                end
            end
            default: state_n = TX_IDLE;
        endcase
        // Line level is registered from the next state so the pin never glitches.
        case (state_n)
            TX_START: tx_n = 1'b0;
            TX_DATA:  tx_n = sh_n[0];
            default:  tx_n = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state != TX_IDLE);

endmodule

// File: rtl/midi_tx.sv
// MIDI message transmitter: latches status + up to two data bytes and sequences them
// through the byte serializer. Optional running status via MIDI_TX_RUNNING_STATUS_EN.
module midi_tx
    import midi_pkg::*;
#(
    parameter int CLK_HZ = 16000000,
    parameter int BAUD   = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] msg_status,
    input  logic [6:0] msg_data1,
    input  logic [6:0] msg_data2,
    output logic       serial_tx,
    output logic       busy
);

    localparam int DIV = CLK_HZ / BAUD;

    logic       ready_q;
    logic       accept, load;
    logic       omit;
    logic [7:0] d1, d2, first_byte, b1_n;
    logic [7:0] b1, b2;
    logic [1:0] rem, n_send;
    logic       u_start, u_busy, u_done, u_tx;
    logic [7:0] u_data;

    assign d1     = {1'b0, msg_data1};
    assign d2     = {1'b0, msg_data2};
    assign accept = msg_valid & msg_ready;
    // A message without bit7 set is swallowed on acceptance.
    assign load   = accept & msg_status[7];

`ifdef MIDI_TX_RUNNING_STATUS_EN
    logic [7:0] run_status;

    assign omit = is_channel(msg_status) && (msg_status == run_status);

    always_ff @(posedge clk) begin
        if (reset)
            run_status <= '0;
        else if (load) begin
            if (is_channel(msg_status))
                run_status <= msg_status;
            else if (msg_status < ST_REALTIME)
                run_status <= '0;
        end
    end
`else
    assign omit = 1'b0;
`endif

    always_comb begin
        n_send     = msg_byte_count(msg_status) - {1'b0, omit};
        first_byte = omit ? d1 : msg_status;
        b1_n       = omit ? d2 : d1;
    end

    // First byte goes straight to the serializer so its start bit lands next cycle.
    assign u_start = load | (u_done & (rem != 2'd0));
    assign u_data  = load ? first_byte : b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            rem     <= '0;
            b1      <= '0;
            b2      <= '0;
        end else if (load) begin
            ready_q <= 1'b0;
            b1      <= b1_n;
            b2      <= d2;
            rem     <= n_send - 2'd1;
        end else if (u_done && rem != 2'd0) begin
            b1  <= b2;
            rem <= rem - 2'd1;
        end else if (u_done || !u_busy) begin
            ready_q <= 1'b1;
        end
    end

    uart_tx_byte #(.DIV(DIV)) u_ser (
        .clk   (clk),
        .reset (reset),
        .start (u_start),
        .data  (u_data),
        .tx    (u_tx),
        .busy  (u_busy),
        .done  (u_done)
    );

    // Reset overrides the outputs immediately so an aborted byte never lingers.
    assign serial_tx = reset | u_tx;
    assign busy      = ~reset & u_busy;
    assign msg_ready = ~reset & ready_q;

endmodule

// File: tb/tb_midi_tx.sv
// Directed bench for midi_tx: decodes 8N1 frames off serial_tx and checks handshake timing.
module tb_midi_tx;

    localparam int CLK_HZ = 500000;
    localparam int BAUD   = 31250;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int FR     = 10 * DIV;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    localparam bit RS = 1'b1;
`else
    localparam bit RS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] msg_status;
    logic [6:0] msg_data1;
    logic [6:0] msg_data2;
    logic       serial_tx;
    logic       busy;

    int checks = 0;
    int fails  = 0;

    midi_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .reset      (reset),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_status (msg_status),
        .msg_data1  (msg_data1),
        .msg_data2  (msg_data2),
        .serial_tx  (serial_tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one message; returns on the cycle after acceptance.
    task automatic send(input logic [7:0] s, input logic [6:0] a, input logic [6:0] b);
        int w = 0;
        while (!msg_ready && w < 50 * FR) begin
            tick();
            w++;
        end
        if (!msg_ready) begin
            chk("ready_wait", 32'd0, 32'd1);
            return;
        end
        msg_status = s;
        msg_data1  = a;
        msg_data2  = b;
        msg_valid  = 1'b1;
        tick();
        msg_valid  = 1'b0;
        msg_status = 8'($urandom);
        msg_data1  = 7'($urandom);
        msg_data2  = 7'($urandom);
    endtask

    // Expect n back-to-back frames starting this cycle, then an idle/ready cycle.
    task automatic rx_msg(input string tag, input int n,
                          input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] exp;
        logic [9:0] fr;
        logic       bad;
        bad = 1'b0;
        fr  = '0;
        for (int k = 0; k < n; k++) begin
            exp = (k == 0) ? e0 : (k == 1) ? e1 : e2;
            chk({tag, "_start_edge"}, {31'd0, serial_tx}, 32'd0);
            for (int t = 0; t < FR; t++) begin
                if (t % DIV == DIV / 2)
                    fr[t / DIV] = serial_tx;
                if (!busy || msg_ready)
                    bad = 1'b1;
                if (t < FR - 1)
                    tick();
            end
            chk({tag, "_frame"}, {22'd0, fr}, {22'd0, 1'b1, exp, 1'b0});
            tick();
        end
        chk({tag, "_busy_ready_hold"}, {31'd0, bad}, 32'd0);
        chk({tag, "_end_idle"}, {29'd0, serial_tx, busy, msg_ready}, 32'b101);
    endtask

    initial begin
        logic bad;
        reset      = 1'b1;
        msg_valid  = 1'b0;
        msg_status = '0;
        msg_data1  = '0;
        msg_data2  = '0;
        repeat (3) tick();
        chk("reset_state", {29'd0, serial_tx, busy, msg_ready}, 32'b100);
        reset = 1'b0;
        tick();
        chk("ready_after_reset", {29'd0, serial_tx, busy, msg_ready}, 32'b101);

        send(8'h90, 7'h3C, 7'h64);
        rx_msg("note_on", 3, 8'h90, 8'h3C, 8'h64);

        send(8'hC5, 7'h07, 7'h7F);
        rx_msg("prog_chg", 2, 8'hC5, 8'h07, 8'h00);

        send(8'h80, 7'h7F, 7'h7F);
        rx_msg("data_msb0", 3, 8'h80, 8'h7F, 8'h7F);

        send(8'h90, 7'h3C, 7'h64);
        rx_msg("b2b_a", 3, 8'h90, 8'h3C, 8'h64);
        send(8'h90, 7'h3E, 7'h50);
        if (RS) rx_msg("b2b_b", 2, 8'h3E, 8'h50, 8'h00);
        else    rx_msg("b2b_b", 3, 8'h90, 8'h3E, 8'h50);

        send(8'hF2, 7'h00, 7'h00);
        rx_msg("sys_a", 1, 8'hF2, 8'h00, 8'h00);
        send(8'h90, 7'h40, 7'h10);
        rx_msg("rt_note_a", 3, 8'h90, 8'h40, 8'h10);
        send(8'hF8, 7'h11, 7'h22);
        rx_msg("rt_clock", 1, 8'hF8, 8'h00, 8'h00);
        send(8'h90, 7'h41, 7'h11);
        if (RS) rx_msg("rt_note_b", 2, 8'h41, 8'h11, 8'h00);
        else    rx_msg("rt_note_b", 3, 8'h90, 8'h41, 8'h11);

        send(8'hF2, 7'h00, 7'h00);
        rx_msg("sys_b", 1, 8'hF2, 8'h00, 8'h00);
        send(8'h90, 7'h40, 7'h10);
        rx_msg("sys_note_a", 3, 8'h90, 8'h40, 8'h10);
        send(8'hF2, 7'h05, 7'h06);
        rx_msg("sys_c", 1, 8'hF2, 8'h00, 8'h00);
        send(8'h90, 7'h41, 7'h11);
        rx_msg("sys_note_b", 3, 8'h90, 8'h41, 8'h11);

        // Abort mid-data of the second byte; running status must be forgotten.
        send(8'hF0, 7'h00, 7'h00);
        rx_msg("sysex_clr", 1, 8'hF0, 8'h00, 8'h00);
        send(8'h90, 7'h42, 7'h12);
        repeat (FR + 4 * DIV) tick();
        chk("pre_abort_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        chk("abort_state", {29'd0, serial_tx, busy, msg_ready}, 32'b100);
        tick();
        reset = 1'b0;
        tick();
        chk("abort_release", {29'd0, serial_tx, busy, msg_ready}, 32'b101);
        send(8'h90, 7'h43, 7'h13);
        rx_msg("post_reset", 3, 8'h90, 8'h43, 8'h13);

        send(8'h3C, 7'h10, 7'h20);
        chk("discard_next", {29'd0, serial_tx, busy, msg_ready}, 32'b101);
        bad = 1'b0;
        for (int t = 0; t < 3 * DIV; t++) begin
            if (!serial_tx || busy || !msg_ready)
                bad = 1'b1;
            tick();
        end
        chk("discard_quiet", {31'd0, bad}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/midi_tx.md
MIDI_TX -- requirements
Module: midi_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 16000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250, serial bit rate; bit period DIV = CLK_HZ/BAUD, integer division (512 at defaults).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port msg_valid  input  1  message offered.
REQ-006 SHALL have port msg_ready  output  1  block can accept a message.
REQ-007 SHALL have port msg_status  input  8  MIDI status byte.
REQ-008 SHALL have port msg_data1  input  7  first data byte (bit7 sent as 0).
REQ-009 SHALL have port msg_data2  input  7  second data byte (bit7 sent as 0).
REQ-010 SHALL have port serial_tx  output  1  MIDI serial out, idle high.
REQ-011 SHALL have port busy  output  1  high while any byte is being serialized.

Function
REQ-012 SHALL accept a message on any cycle with msg_valid && msg_ready, latching all three fields that cycle.
REQ-013 SHALL deassert msg_ready the cycle after acceptance, keeping it low until the last stop bit of the message completes.
REQ-014 SHALL derive byte count from msg_status: 0x80-0xBF and 0xE0-0xEF -> 3; 0xC0-0xDF -> 2; 0xF0-0xFF -> 1 (status only; SysEx data is not supported).
REQ-015 SHALL accept and discard a message whose msg_status bit7 = 0, emitting nothing; msg_ready SHALL return high the next cycle.
REQ-016 SHALL frame each byte as 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit exactly DIV clocks (10*DIV clocks per byte).
REQ-017 SHALL drive the first start bit on the cycle after acceptance (one-cycle latency), with no idle gap between bytes of one message.
REQ-018 SHALL implement states IDLE -> START -> DATA -> STOP -> (next byte ? START : IDLE); the bit counter wraps 0..7 in DATA and the baud counter wraps 0..DIV-1.
REQ-019 SHALL re-assert msg_ready on the first cycle after the final stop bit period; a valid message presented then starts its start bit on the following cycle.
REQ-020 SHALL hold busy high from the cycle after acceptance through the last stop bit cycle, low otherwise.
REQ-021 SHALL ignore msg_valid and the message fields while msg_ready is low; inputs may change freely then.

Reset
REQ-022 SHALL, while reset is high, force state IDLE, serial_tx = 1, busy = 0, msg_ready = 0, and clear all counters and the running-status register.
REQ-023 SHALL raise msg_ready on the first cycle after reset deasserts.
REQ-024 SHALL abort any in-flight byte on reset, returning serial_tx high in the same cycle reset is sampled.

Configuration
REQ-025 SHALL support macro MIDI_TX_RUNNING_STATUS_EN; when defined, a channel message (0x80-0xEF) whose status equals the last transmitted status SHALL omit the status byte.
REQ-026 With MIDI_TX_RUNNING_STATUS_EN, realtime statuses 0xF8-0xFF SHALL leave the running status unchanged; 0xF0-0xF7 SHALL clear it.
REQ-027 Without MIDI_TX_RUNNING_STATUS_EN, every message SHALL include its status byte and no running-status register SHALL exist.

Structure
REQ-028 SHALL place status class constants (0x80, 0x90, 0xC0, 0xD0, 0xF0, 0xF8), default BAUD and the byte-count function in shared package midi_pkg.
REQ-029 SHALL instantiate one sub-module uart_tx_byte (byte-level 8N1 serializer with start/done handshake); midi_tx owns message sequencing and running status.

Verification
REQ-030 Note-on 0x90,0x3C,0x64 at defaults -> 3 frames 0x90,0x3C,0x64; total 15360 clocks; start bit 1 cycle after accept; msg_ready low throughout.
REQ-031 Program change 0xC5,0x07 (data2 = 0x7F) -> 2 frames 0xC5,0x07, no third byte; data bit7 sent as 0.
REQ-032 Two 0x90 notes back-to-back, macro defined -> 3 + 2 frames (second status omitted); macro undefined -> 6 frames.
REQ-033 0x90 note, then 0xF8, then 0x90 note, macro defined -> 3, 1, 2 frames; with 0xF2 in place of 0xF8 -> 3, 1, 3 frames.
REQ-034 Reset asserted mid-DATA of byte 2 -> serial_tx = 1 and busy = 0 that cycle; msg_ready = 1 the cycle after release; next 0x90 message sent with status byte.
REQ-035 msg_status 0x3C with valid -> no line activity, busy stays 0, msg_ready high again next cycle.
